ioctl_mem_loader: RTL and testbench
===================================

// Module: ioctl_mem_loader
// PURPOSE
//  Multi-channel download router between data_io (ioctl_*) and core memory/keyboard. Binary channels are
//  written to SDRAM through a depth-buffered, ready-handshaked write port at a per-channel base address.
//  The TXT channel is instead paced out as keystrokes, translated to Apple-1 conventions.
//  Sits in the top level between data_io, sdram and the machine core.
// PARAMETERS
//  ADDR_W      16           memory address width; addresses wrap modulo 2**ADDR_W
//  NUM_CH      4            binary channels, selected by ioctl_index[CH_W-1:0], CH_W=$clog2(NUM_CH)
//  CH_BASE     {NUM_CH{16'h0}}  packed per-channel base addresses, ADDR_W bits each, ch0 in LSBs
//  TXT_INDEX   8'd0         ioctl_index value routed to the key stream (overrides binary map)
//  FIFO_DEPTH  16           byte FIFO depth, power of two, >=2
//  CHAR_GAP    16'd2000     clk_sys cycles idle after each accepted key
//  LINE_GAP    16'd50000    clk_sys cycles idle after an accepted CR (replaces CHAR_GAP)
// PORTS
//  clk_sys        in   1       system clock
//  reset          in   1       asynchronous, active-high
//  ioctl_download in   1       download window from data_io
//  ioctl_index    in   8       file/channel index
//  ioctl_wr       in   1       byte strobe, one cycle
//  ioctl_addr     in   25      byte offset within file
//  ioctl_dout     in   8       byte
//  mem_addr       out  ADDR_W  write address
//  mem_din        out  8       write data
//  mem_wr         out  1       write request, held until mem_ready
//  mem_ready      in   1       write accepted
//  key_data       out  8       translated key code
//  key_valid      out  1       key available, held until key_ready
//  key_ready      in   1       core consumed key
//  busy           out  1       download or drain in progress
//  overflow       out  1       sticky: byte dropped on full FIFO
//  bad_index      out  1       sticky: index neither TXT_INDEX nor < NUM_CH
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, gap counter 0; reset mid-transfer abandons it, no replay.
//  Rising ioctl_download: latch index/mode for whole window; clear overflow and bad_index.
//  Push: ioctl_wr & download & valid index -> FIFO {offset[ADDR_W-1:0], byte}; full -> drop, overflow=1.
//  Push and pop in same cycle on full FIFO: both happen, no overflow.
//  Invalid index: bytes dropped, bad_index=1, nothing written.
//  FSM IDLE -> MEM_WR (binary, FIFO not empty): pop; mem_addr=CH_BASE[ch]+offset (mod 2**ADDR_W).
//  MEM_WR: mem_wr=1, addr/din stable until mem_ready=1 sampled -> IDLE; mem_wr low next cycle.
//  Min one idle cycle between writes; pop-to-mem_wr latency 1 cycle.
//  IDLE -> KEY (TXT mode, FIFO not empty, gap counter 0): pop and translate.
//  Translate: 0x0A->0x0D; 'a'..'z'->'A'..'Z'; bit7 forced 1; 0x0D following 0x0D/0x0A of a CRLF pair
//  dropped (no key); other codes pass.
//  KEY: key_valid=1 until key_ready=1 -> GAP; counter loads LINE_GAP if key was CR else CHAR_GAP.
//  GAP: decrement to 0 -> IDLE.
//  busy = download | FIFO not empty | state!=IDLE; falls one cycle after last drain completes.
//  New download starting while draining: new bytes queue behind old; mode switches only once FIFO
//  empty and FSM IDLE (mode of each byte stored with it).
// STRUCTURE
//  Package ioctl_loader_pkg: state enum {IDLE,MEM_WR,KEY,GAP}, ASCII_CR/ASCII_LF constants,
//  translate_key() function.
//  Sub-module loader_fifo: synchronous FIFO, async reset, full/empty, simultaneous push/pop.
// TESTING
//  Ch1 base 0xE000, write bytes 11,22 @offset 0,1, mem_ready after 3 cyc -> writes E000=11, E001=22.
//  Ch1 offset 0x3000, base 0xE000 -> mem_addr 0x1000 (wrap); index 9 -> no write, bad_index=1.
//  TXT "ab\r\n" -> keys C1,C2,8D only; GAP: 2000 cyc after C1, 50000 after 8D.
//  20 ioctl_wr back-to-back, mem_ready never high -> 16 queued, overflow=1; next download clears it.
//  Assert reset during MEM_WR -> mem_wr, key_valid, busy 0 same cycle; FIFO empty after release.
//  Hold key_ready low 100 cyc -> key_valid and key_data stable throughout; no pop.

Source files
------------

// File: rtl/ioctl_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ioctl_loader_pkg                                             |
// | Description : Shared types and helpers for the ioctl download router:      |
// |               FSM state encoding, ASCII constants and the Apple-1 key      |
// |               translation function.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ioctl_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_WR = 2'd1,
        KEY    = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Returns {drop, code}. LF becomes CR, lower case is folded to upper case
    // and bit 7 is always set (Apple-1 keyboard convention). The second half
    // of a CR/LF or LF/CR pair is dropped so a host line ending yields one key.
    function automatic logic [8:0] translate_key(
        input logic [7:0] raw,
        input logic       prev_cr,
        input logic       prev_lf
    );
        logic [7:0] code;
        logic       drop;
        code = raw;
        drop = 1'b0;
        if (raw == ASCII_LF) begin
            code = ASCII_CR;
            drop = prev_cr;
        end else if (raw == ASCII_CR) begin
            drop = prev_lf;
        end else if ((raw >= 8'h61) && (raw <= 8'h7A)) begin
            code = raw - 8'h20;
        end
        code[7] = 1'b1;
        return {drop, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : loader_fifo                                                  |
// | Description : Synchronous show-ahead FIFO with asynchronous reset.         |
// |               A push on a full FIFO is accepted when a pop happens in the  |
// |               same cycle.                                                  |
// | Ports       : clk, rst        clock, async active-high reset               |
// |               i_push/i_push_data   write side                              |
// |               i_pop/o_pop_data     read side (o_pop_data = head entry)     |
// |               o_full/o_empty       occupancy flags                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module loader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);

    assign o_pop_data = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/ioctl_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ioctl_mem_loader                                             |
// | Description : Routes data_io downloads either to an SDRAM write port       |
// |               (binary channels, per-channel base address) or to a paced    |
// |               Apple-1 keystroke stream (TXT channel).                      |
// | Ports       : clk_sys, reset          clock, async active-high reset       |
// |               ioctl_*                 data_io download interface           |
// |               mem_addr/din/wr/ready   buffered SDRAM write port            |
// |               key_data/valid/ready    translated key stream                |
// |               busy/overflow/bad_index status                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ioctl_mem_loader
    import ioctl_loader_pkg::*;
#(
    parameter int                       ADDR_W     = 16,
    parameter int                       NUM_CH     = 4,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE    = '0,
    parameter logic [7:0]               TXT_INDEX  = 8'd0,
    parameter int                       FIFO_DEPTH = 16,
    parameter logic [15:0]              CHAR_GAP   = 16'd2000,
    parameter logic [15:0]              LINE_GAP   = 16'd50000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_wr,
    input  logic              mem_ready,
    output logic [7:0]        key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              busy,
    output logic              overflow,
    output logic              bad_index
);

    localparam int         c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // FIFO entry: {txt_mode, channel, offset, byte}
    localparam int         c_ent_w  = 1 + c_ch_w + ADDR_W + 8;
    localparam logic [7:0] c_key_cr = ASCII_CR | 8'h80;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_dl_prev;
    logic [7:0]           r_index;
    logic [7:0]           w_index;
    logic                 w_dl_rise;
    logic                 w_is_txt;
    logic                 w_is_bin;
    logic                 w_idx_ok;
    logic                 w_wr_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [c_ent_w-1:0]   w_push_data;
    logic [c_ent_w-1:0]   w_head;
    logic                 w_head_txt;
    logic [c_ch_w-1:0]    w_head_ch;
    logic [ADDR_W-1:0]    w_head_off;
    logic [7:0]           w_head_byte;
    logic [8:0]           w_xlat;
    logic                 w_load_mem;
    logic                 w_load_key;
    logic [ADDR_W-1:0]    w_base [NUM_CH];
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [7:0]           r_mem_din;
    logic [7:0]           r_key_data;
    logic [15:0]          r_gap;
    logic                 r_prev_cr;
    logic                 r_prev_lf;
    logic                 r_overflow;
    logic                 r_bad_index;
    logic                 w_unused_addr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_base
        assign w_base[g] = CH_BASE[g*ADDR_W +: ADDR_W];
    end

    // Only the low ADDR_W bits of the file offset take part in addressing.
    assign w_unused_addr = ^ioctl_addr;

    // The index is taken live on the first cycle of a window so a byte
    // strobed together with the download edge is routed correctly.
    assign w_dl_rise = ioctl_download & ~r_dl_prev;
    assign w_index   = w_dl_rise ? ioctl_index : r_index;
    assign w_is_txt  = (w_index == TXT_INDEX);
    assign w_is_bin  = ({24'd0, w_index} < 32'(NUM_CH));
    assign w_idx_ok  = w_is_txt | w_is_bin;
    assign w_wr_req  = ioctl_download & ioctl_wr;
    assign w_push    = w_wr_req & w_idx_ok;
    assign w_drop    = w_push & w_full & ~w_pop;

    assign w_push_data = {w_is_txt, w_index[c_ch_w-1:0], ioctl_addr[ADDR_W-1:0], ioctl_dout};

    loader_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk_sys),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign w_head_txt  = w_head[c_ent_w-1];
    assign w_head_ch   = w_head[8+ADDR_W +: c_ch_w];
    assign w_head_off  = w_head[8 +: ADDR_W];
    assign w_head_byte = w_head[7:0];
    assign w_xlat      = translate_key(w_head_byte, r_prev_cr, r_prev_lf);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // The mode travels with each FIFO entry, so a new window queued behind
    // an old one only changes routing once its own bytes reach the head.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_mem  = 1'b0;
        w_load_key  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    if (!w_head_txt) begin
                        w_pop       = 1'b1;
                        w_load_mem  = 1'b1;
                        w_state_nxt = MEM_WR;
                    end else if (r_gap == 16'd0) begin
                        w_pop = 1'b1;
                        // A dropped CR/LF partner is consumed without a key.
                        if (!w_xlat[8]) begin
                            w_load_key  = 1'b1;
                            w_state_nxt = KEY;
                        end
                    end
                end
            end
            MEM_WR:  if (mem_ready)        w_state_nxt = IDLE;
            KEY:     if (key_ready)        w_state_nxt = GAP;
            GAP:     if (r_gap <= 16'd1)   w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dl_prev   <= 1'b0;
            r_index     <= 8'd0;
            r_mem_addr  <= '0;
            r_mem_din   <= 8'd0;
            r_key_data  <= 8'd0;
            r_gap       <= 16'd0;
            r_prev_cr   <= 1'b0;
            r_prev_lf   <= 1'b0;
            r_overflow  <= 1'b0;
            r_bad_index <= 1'b0;
        end else begin
            r_dl_prev <= ioctl_download;
            if (w_dl_rise) r_index <= ioctl_index;

            if (w_dl_rise)   r_overflow <= w_drop;
            else if (w_drop) r_overflow <= 1'b1;

            if (w_dl_rise)                   r_bad_index <= ~w_idx_ok;
            else if (w_wr_req && !w_idx_ok)  r_bad_index <= 1'b1;

            if (w_load_mem) begin
                r_mem_addr <= w_base[w_head_ch] + w_head_off;
                r_mem_din  <= w_head_byte;
            end

            if (w_load_key) r_key_data <= w_xlat[7:0];

            if (w_pop && w_head_txt) begin
                r_prev_cr <= (w_head_byte == ASCII_CR) && !w_xlat[8];
                r_prev_lf <= (w_head_byte == ASCII_LF) && !w_xlat[8];
            end

            if ((r_state == KEY) && key_ready)
                r_gap <= (r_key_data == c_key_cr) ? LINE_GAP : CHAR_GAP;
            else if ((r_state == GAP) && (r_gap != 16'd0))
                r_gap <= r_gap - 16'd1;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_wr    = (r_state == MEM_WR);
    assign key_data  = r_key_data;
    assign key_valid = (r_state == KEY);
    assign overflow  = r_overflow;
    assign bad_index = r_bad_index;
    assign busy      = ~reset & (ioctl_download | ~w_empty | (r_state != IDLE));

endmodule
`default_nettype wire

// File: tb/tb_ioctl_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ioctl_mem_loader                                          |
// | Description : Scoreboard bench for ioctl_mem_loader. Stimulus pushes the   |
// |               expected memory writes / keys; monitors pop and compare.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ioctl_mem_loader;

    localparam int          ADDR_W    = 16;
    localparam int          NUM_CH    = 4;
    localparam logic [63:0] CH_BASE   = {16'h8000, 16'h1234, 16'hE000, 16'h0000};
    localparam logic [7:0]  TXT_INDEX = 8'd0;
    localparam int          CHAR_GAP  = 2000;
    localparam int          LINE_GAP  = 50000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        mem_ready = 1'b0;
    logic        key_ready = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_wr;
    logic [7:0]  key_data;
    logic        key_valid;
    logic        busy;
    logic        overflow;
    logic        bad_index;

    ioctl_mem_loader #(
        .ADDR_W     (ADDR_W),
        .NUM_CH     (NUM_CH),
        .CH_BASE    (CH_BASE),
        .TXT_INDEX  (TXT_INDEX),
        .FIFO_DEPTH (16),
        .CHAR_GAP   (16'(CHAR_GAP)),
        .LINE_GAP   (16'(LINE_GAP))
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_wr         (mem_wr),
        .mem_ready      (mem_ready),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .busy           (busy),
        .overflow       (overflow),
        .bad_index      (bad_index)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues
    logic [23:0] mem_q[$];       // {addr, data}
    logic [7:0]  key_code_q[$];
    int          key_gap_q[$];   // expected key_valid-low cycles before this key, 0 = unchecked

    // Reference-model state
    logic [7:0]  cur_idx = 8'd0;
    int          accept_left = -1;  // bytes the DUT can still absorb, -1 = unlimited
    int          pend_nl = 0;       // raw CR/LF that may pair with the next byte
    int          last_gap_n = -1;
    int          drops_since = 0;

    // Stimulus-side handshake controls
    bit          ready_en = 1'b0;
    int          ready_delay = 0;
    bit          stall_next = 1'b0;
    int          stall_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Text model: a newline pairs with an immediately preceding newline of the
    // other kind and is swallowed. Each key is followed by CHAR_GAP idle cycles
    // (LINE_GAP for CR); the DUT spends one further cycle fetching each byte,
    // so key_valid stays low for gap+1 cycles plus one per swallowed byte.
    function automatic void model_txt(input logic [7:0] raw);
        logic [7:0] code;
        bit nl;
        nl = (raw == 8'h0D) || (raw == 8'h0A);
        if (nl && pend_nl != 0 && pend_nl != int'(raw)) begin
            drops_since++;
            pend_nl = 0;
            return;
        end
        if (nl)                           code = 8'h8D;
        else if (raw inside {[8'h61:8'h7A]}) code = (raw - 8'h20) | 8'h80;
        else                              code = raw | 8'h80;
        pend_nl = nl ? int'(raw) : 0;
        key_code_q.push_back(code);
        key_gap_q.push_back((last_gap_n < 0) ? 0 : last_gap_n + 1 + drops_since);
        last_gap_n  = (code == 8'h8D) ? LINE_GAP : CHAR_GAP;
        drops_since = 0;
    endfunction

    function automatic void model_push(input logic [24:0] addr, input logic [7:0] d);
        logic [15:0] base;
        if (accept_left == 0) return;
        if (accept_left > 0) accept_left--;
        if (cur_idx == TXT_INDEX) begin
            model_txt(d);
        end else if (int'(cur_idx) < NUM_CH) begin
            base = CH_BASE[int'(cur_idx)*16 +: 16];
            mem_q.push_back({16'((int'(base) + int'(addr)) % 65536), d});
        end
    endfunction

    task automatic dl_begin(input logic [7:0] idx);
        @(posedge clk_sys); #1;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        cur_idx        = idx;
        if (idx == TXT_INDEX) begin
            last_gap_n  = -1;
            drops_since = 0;
        end
    endtask

    task automatic put(input logic [24:0] addr, input logic [7:0] d);
        ioctl_addr = addr;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        model_push(addr, d);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((mem_q.size() != 0 || key_code_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk_sys); #1;
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    // mem_ready responder: raised after ready_delay cycles of mem_wr
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk_sys); #1;
            if (!ready_en) begin
                mem_ready = 1'b0;
                wcnt = 0;
            end else if (mem_wr) begin
                wcnt++;
                mem_ready = (wcnt >= ready_delay);
            end else begin
                wcnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // key_ready driver: random acceptance, optional 100-cycle stall
    initial begin
        forever begin
            @(posedge clk_sys); #1;
            if (key_valid && stall_next && stall_cnt < 100) begin
                key_ready = 1'b0;
                stall_cnt++;
            end else begin
                key_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Monitor: compares every accepted write/key with the scoreboard
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        prev_mw = 1'b0, prev_macc = 1'b0, prev_kv = 1'b0, prev_kacc = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_din = '0, prev_kd = '0;

    always @(negedge clk_sys) begin
        cyc++;
        if (reset) begin
            prev_mw = 1'b0; prev_macc = 1'b0; prev_kv = 1'b0; prev_kacc = 1'b0;
        end else begin
            if (mem_wr && prev_mw && !prev_macc) begin
                chk("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
                chk("mem_din_stable", 32'(mem_din), 32'(prev_din));
            end
            if (mem_wr && mem_ready) begin
                checks++;
                if (mem_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_unexpected: got write 0x%0h=0x%0h, expected none", mem_addr, mem_din);
                end else begin
                    logic [23:0] e;
                    e = mem_q.pop_front();
                    if ({mem_addr, mem_din} !== e) begin
                        errors++;
                        $display("FAIL mem_write: got 0x%0h=0x%0h, expected 0x%0h=0x%0h",
                                 mem_addr, mem_din, e[23:8], e[7:0]);
                    end
                end
            end
            if (key_valid && !prev_kv && key_gap_q.size() != 0 && key_gap_q[0] != 0)
                chk("key_gap", 32'(cyc - acc_cyc - 1), 32'(key_gap_q[0]));
            if (key_valid && prev_kv && !prev_kacc)
                chk("key_data_stable", 32'(key_data), 32'(prev_kd));
            if (key_valid && key_ready) begin
                checks++;
                if (key_code_q.size() == 0) begin
                    errors++;
                    $display("FAIL key_unexpected: got 0x%0h, expected none", key_data);
                end else begin
                    logic [7:0] ec;
                    ec = key_code_q.pop_front();
                    void'(key_gap_q.pop_front());
                    if (key_data !== ec) begin
                        errors++;
                        $display("FAIL key_data: got 0x%0h, expected 0x%0h", key_data, ec);
                    end
                end
                acc_cyc = cyc;
            end
            prev_mw   = mem_wr;
            prev_macc = mem_wr && mem_ready;
            prev_addr = mem_addr;
            prev_din  = mem_din;
            prev_kv   = key_valid;
            prev_kacc = key_valid && key_ready;
            prev_kd   = key_data;
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] txt1 [5];
        txt1[0] = "a"; txt1[1] = "b"; txt1[2] = 8'h0D; txt1[3] = 8'h0A; txt1[4] = "x";

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_din", 32'(mem_din), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_key_data", 32'(key_data), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_bad_index", 32'(bad_index), 0);
        reset = 1'b0;

        // Invalid index: nothing written, sticky flag
        ready_en = 1'b1;
        dl_begin(8'd9);
        put(25'd0, 8'h55);
        put(25'd1, 8'h66);
        chk("bad_index_set", 32'(bad_index), 1);
        ioctl_download = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        chk("bad_index_sticky", 32'(bad_index), 1);

        // Ch1 basic writes, mem_ready after 3 cycles; new window clears bad_index
        ready_delay = 3;
        dl_begin(8'd1);
        put(25'd0, 8'h11);
        chk("bad_index_clear", 32'(bad_index), 0);
        put(25'd1, 8'h22);
        chk("busy_during_dl", 32'(busy), 1);
        ioctl_download = 1'b0;
        wait_drain(500, "drain_basic");

        // Address wrap
        ready_delay = 0;
        dl_begin(8'd1);
        put(25'h3000, 8'h77);
        ioctl_download = 1'b0;
        wait_drain(500, "drain_wrap");

        // Randomised binary windows
        for (int w = 0; w < 4; w++) begin
            ready_delay = $urandom_range(0, 4);
            dl_begin(8'($urandom_range(1, 3)));
            for (int i = 0; i < 8; i++) begin
                put(25'($urandom), 8'($urandom));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk_sys); #1;
                end
            end
            ioctl_download = 1'b0;
            wait_drain(2000, "drain_rand_bin");
        end

        // Overflow: sink stalled; 16 entries fit in the FIFO plus one held in the write port
        ready_en = 1'b0;
        accept_left = 17;
        dl_begin(8'd2);
        for (int i = 0; i < 20; i++) put(25'(i), 8'($urandom));
        ioctl_download = 1'b0;
        chk("overflow_set", 32'(overflow), 1);
        accept_left = -1;
        dl_begin(8'd3);
        @(posedge clk_sys); #1;
        chk("overflow_clear", 32'(overflow), 0);
        ioctl_download = 1'b0;
        ready_en = 1'b1;
        ready_delay = 1;
        wait_drain(2000, "drain_overflow");

        // Reset during MEM_WR abandons everything
        ready_en = 1'b0;
        dl_begin(8'd1);
        put(25'd4, 8'hA5);
        put(25'd5, 8'hA6);
        put(25'd6, 8'hA7);
        ioctl_download = 1'b0;
        begin
            int n = 0;
            while (!mem_wr && n < 20) begin
                @(posedge clk_sys); #1;
                n++;
            end
            chk("mem_wr_before_reset", 32'(mem_wr), 1);
        end
        @(posedge clk_sys); #2;
        reset = 1'b1;
        #1;
        chk("reset_mem_wr", 32'(mem_wr), 0);
        chk("reset_key_valid", 32'(key_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        mem_q.delete();
        pend_nl = 0;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        ready_en = 1'b1;
        ready_delay = 0;
        repeat (10) @(posedge clk_sys);
        #1;
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_mem_wr", 32'(mem_wr), 0);

        // TXT stream "ab\r\nx": keys C1 C2 8D D8, line gap after CR
        dl_begin(TXT_INDEX);
        for (int i = 0; i < 5; i++) put(25'(i), txt1[i]);
        ioctl_download = 1'b0;
        wait_drain(60000, "drain_txt");

        // Random text with a 100-cycle key_ready stall on its first key
        stall_next = 1'b1;
        dl_begin(TXT_INDEX);
        for (int i = 0; i < 7; i++) begin
            logic [7:0] c;
            c = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom);
            if (c == 8'h0A || c == 8'h0D || c == 8'h8A || c == 8'h8D) c = 8'h21;
            put(25'(i), c);
        end
        ioctl_download = 1'b0;
        wait_drain(30000, "drain_txt_rand");
        chk("stall_applied", 32'(stall_cnt), 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
